// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - 7-segment pattern constants, error codes and decoder FSM state
// Active-low segment encodings, bit0=a .. bit6=g, shared with the hex encoder.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PATTERN = 2'b01;
  localparam logic [1:0] ERR_ANODE   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_LOCKED
  } dec_state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg_code_t;

endpackage

// File: rtl/seg_pattern_lut.sv
// rtl/seg_pattern_lut.sv - combinational segment pattern to {legal, blank, nibble} lookup
module seg_pattern_lut
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output seg_code_t  code
);

  always_comb begin
    code = {1'b0, 1'b0, 4'h0};
    case (seg)
      SEG_0:     code = {1'b1, 1'b0, 4'h0};
      SEG_1:     code = {1'b1, 1'b0, 4'h1};
      SEG_2:     code = {1'b1, 1'b0, 4'h2};
      SEG_3:     code = {1'b1, 1'b0, 4'h3};
      SEG_4:     code = {1'b1, 1'b0, 4'h4};
      SEG_5:     code = {1'b1, 1'b0, 4'h5};
      SEG_6:     code = {1'b1, 1'b0, 4'h6};
      SEG_7:     code = {1'b1, 1'b0, 4'h7};
      SEG_8:     code = {1'b1, 1'b0, 4'h8};
      SEG_9:     code = {1'b1, 1'b0, 4'h9};
      SEG_A:     code = {1'b1, 1'b0, 4'hA};
      SEG_B:     code = {1'b1, 1'b0, 4'hB};
      SEG_C:     code = {1'b1, 1'b0, 4'hC};
      SEG_D:     code = {1'b1, 1'b0, 4'hD};
      SEG_E:     code = {1'b1, 1'b0, 4'hE};
      SEG_F:     code = {1'b1, 1'b0, 4'hF};
      SEG_BLANK: code = {1'b0, 1'b1, 4'h0};
      default:   code = {1'b0, 1'b0, 4'h0};
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - debounced decoder for a multiplexed active-low 7-segment bus
// SEG_DEC_TIMEOUT_EN adds per-digit age counters that expire stale digits.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int STABLE  = 4,
  parameter int TIMEOUT = 65535
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_ok,
  output logic [DIGITS-1:0]     digit_blank,
  output logic                  upd_pulse,
  output logic [3:0]            upd_idx,
  output logic                  err_pulse,
  output logic [1:0]            err_code
);

  localparam int             RW      = $clog2(STABLE + 1);
  localparam logic [RW-1:0]  RUN_MAX = RW'(STABLE);

  logic [6:0]        seg_q, seg_p;
  logic [DIGITS-1:0] an_q, an_p;
  dec_state_t        state, state_nx;
  logic [RW-1:0]     run, run_nx;
  logic              accept, same, one_hot, an_conf, an_conf_p;
  logic              err_nx;
  logic [1:0]        err_code_nx;
  logic [3:0]        idx;
  seg_code_t         code;

  function automatic logic is_one_hot_low(input logic [DIGITS-1:0] a);
    logic [DIGITS-1:0] inv;
    inv = ~a;
    return (inv != '0) && ((inv & (inv - DIGITS'(1))) == '0);
  endfunction

  function automatic logic is_conflict(input logic [DIGITS-1:0] a);
    return (a != '1) && !is_one_hot_low(a);
  endfunction

  seg_pattern_lut u_lut (
    .seg  (seg_q),
    .code (code)
  );

  // Sample regs reset to an idle bus so the first cycle out of reset is not a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      seg_p <= SEG_BLANK;
      an_q  <= '1;
      an_p  <= '1;
    end else begin
      seg_q <= seg;
      seg_p <= seg_q;
      an_q  <= an;
      an_p  <= an_q;
    end
  end

  assign same      = (seg_q == seg_p) && (an_q == an_p);
  assign one_hot   = is_one_hot_low(an_q);
  assign an_conf   = is_conflict(an_q);
  assign an_conf_p = is_conflict(an_p);

  always_comb begin
    idx = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      run   <= '0;
    end else begin
      state <= state_nx;
      run   <= run_nx;
    end
  end

  always_comb begin
    state_nx = state;
    run_nx   = run;
    accept   = 1'b0;
    if (!one_hot) begin
      state_nx = ST_IDLE;
      run_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_TRACK;
          run_nx   = RW'(1);
        end
        ST_TRACK: begin
          if (!same)               run_nx = RW'(1);
          else if (run != RUN_MAX) run_nx = run + RW'(1);
        end
        ST_LOCKED: begin
          if (!same) begin
            state_nx = ST_TRACK;
            run_nx   = RW'(1);
          end
        end
        default: begin
          state_nx = ST_IDLE;
          run_nx   = '0;
        end
      endcase
      // Reaching STABLE accepts immediately, so STABLE=1 accepts on the first sample.
      if (state_nx == ST_TRACK && run_nx == RUN_MAX) begin
        accept   = 1'b1;
        state_nx = ST_LOCKED;
      end
    end
  end

  always_comb begin
    err_nx      = 1'b0;
    err_code_nx = ERR_NONE;
    if (an_conf && !an_conf_p) begin
      err_nx      = 1'b1;
      err_code_nx = ERR_ANODE;
    end else if (accept && !code.legal && !code.blank) begin
      err_nx      = 1'b1;
      err_code_nx = ERR_PATTERN;
    end
  end

`ifdef SEG_DEC_TIMEOUT_EN
  localparam int            AW      = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT);
  logic [AW-1:0] age [DIGITS];
`else
  // Keeps TIMEOUT referenced when the age counters are compiled out.
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_pulse   <= 1'b0;
      upd_idx     <= 4'h0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_NONE;
      digit_val   <= '0;
      digit_ok    <= '0;
      digit_blank <= '0;
`ifdef SEG_DEC_TIMEOUT_EN
      for (int i = 0; i < DIGITS; i++) age[i] <= '0;
`endif
    end else begin
      upd_pulse <= accept;
      err_pulse <= err_nx;
      err_code  <= err_code_nx;
      if (accept) upd_idx <= idx;
      for (int i = 0; i < DIGITS; i++) begin
        if (accept && idx == 4'(i)) begin
          digit_ok[i]    <= code.legal;
          digit_blank[i] <= code.blank;
          if (code.legal) digit_val[4*i +: 4] <= code.nibble;
`ifdef SEG_DEC_TIMEOUT_EN
          age[i] <= '0;
        end else if (age[i] != AGE_MAX) begin
          age[i] <= age[i] + AW'(1);
          if (age[i] == AGE_MAX - AW'(1)) begin
            digit_ok[i]    <= 1'b0;
            digit_blank[i] <= 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule
